fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined MIPS core. It replaces per-pipeline-register compare logic with an internal scoreboard: a shift pipeline of destination tags covering the stages after ID. At issue time it decides the EX-stage forwarding selects and registers them into the ID/EX slot. It generates the load-use stall, optionally forwards branch operands in ID, and counts stall cycles.

## Interface
- AW, 5: register address width.
- DEPTH, 3: tracked stages after ID. Stage 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB, etc.
- LD_RDY, 3: first stage index from which a load result is forwardable. An ALU result is forwardable from stage 2.
- SELW, $clog2(DEPTH+1): forward select width (derived).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- hold  in  1  global freeze (memory wait). No state changes while high.
- flush  in  1  kill the ID instruction; a bubble enters stage 1.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  ID source registers.
- id_use_rs, id_use_rt  in  1  operand is actually read (rt includes store data).
- id_rd  in  AW  ID destination register.
- id_regwrite, id_memread  in  1  ID control bits.
- id_branch  in  1  ID is beq/bne (used only with FWD_BRANCH_EN).
- id_stall  out  1  combinational. Hold PC and IF/ID; a bubble enters stage 1.
- ex_fwd_a, ex_fwd_b  out  SELW  registered EX operand select. 0 = ID/EX latched register-file value; k = result of stage k.
- id_fwd_a, id_fwd_b  out  SELW  combinational branch-compare select (0 = register file).
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Each stage entry is {valid, regwrite, memread, rd}. Stage k matches source s when valid && regwrite && rd != 0 && rd == s && the matching use bit is set.
- If more than one stage matches, the smallest k (youngest producer) wins.
- EX select, computed in ID: the winning stage k will be at k+1 when the consumer reaches EX.
  - If k+1 > DEPTH: select 0. The register file is write-first, so the value is already correct.
  - Else if memread_k && k+1 < LD_RDY: set stall.
  - Else: select k+1.
- id_stall = id_valid && !flush && (EX-stage stall from either operand || branch stall). It is 0 when nothing matches.
- Advance (hold = 0):
  - Stage k+1 loads stage k; stage DEPTH drops out.
  - Stage 1 and ex_fwd_*:
    - flush or id_stall or !id_valid: stage 1 gets a bubble (valid = 0) and ex_fwd_* becomes 0.
    - Otherwise: stage 1 loads the ID fields and ex_fwd_* load the computed selects.
- hold = 1: all entries, ex_fwd_* and stall_cnt are frozen. id_stall is still driven.
- stall_cnt increments when id_stall && !hold and saturates at 0xFFFF.
- flush and id_stall together: flush wins and id_stall reads 0.

## Timing
- Reset values: all entries invalid, ex_fwd_a/b = 0, stall_cnt = 0, id_stall = 0, id_fwd_a/b = 0.
- ex_fwd_* are valid for the whole cycle the consumer occupies EX, one clock after its ID cycle.
- Load-use with defaults costs exactly 1 stall cycle. The general stall length is LD_RDY-1-k cycles for a producer at stage k.
- Reset asserted mid-operation clears state immediately. The first advance after reset deassertion treats the pipeline as empty.

## Configuration
- FWD_BRANCH_EN defined: when id_branch && id_valid, each used source is checked against the winning stage k, evaluated at ID time with no +1.
  - k = 1: stall.
  - memread_k && k < LD_RDY: stall.
  - Otherwise id_fwd = k.
- FWD_BRANCH_EN undefined: id_fwd_a/b are tied to 0, id_branch is ignored, and branches add no stall terms.

## Test plan
- add $8 issued, sub $9,$8,$1 next cycle → no stall; ex_fwd_a = 2 during sub's EX cycle.
- lw $9 then add $10,$9,$9 → id_stall = 1 for one cycle, stall_cnt = 1; then ex_fwd_a = ex_fwd_b = 3.
- add $0,$1,$2 then or $3,$0,$0 → ex_fwd = 0, no stall. Producer three back (stage 3 at ID) → ex_fwd = 0 via write-first register file.
- add $8 then sub $8, then and $4,$8,$8 → ex_fwd_a = 2 (youngest producer). Assert flush on the and → stage 1 bubble, ex_fwd = 0.
- hold raised during a load-use stall → entries, ex_fwd and stall_cnt unchanged. Assert reset mid-run → all outputs 0 asynchronously.
- FWD_BRANCH_EN: add $8, then beq $8,$0 → 1-cycle stall, then id_fwd_a = 2. lw $8, then beq → 2 stall cycles, then id_fwd_a = 3. Without the macro → id_fwd = 0 and no stall.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Issue-side bundle between the ID stage and fwd_scoreboard: ID operand/destination
// fields and control in, stall and forwarding selects out.
interface fwd_scoreboard_if #(
    parameter int AW    = 5,
    parameter int DEPTH = 3
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic            i_hold;
    logic            i_flush;
    logic            i_id_valid;
    logic [AW-1:0]   i_id_rs;
    logic [AW-1:0]   i_id_rt;
    logic            i_id_use_rs;
    logic            i_id_use_rt;
    logic [AW-1:0]   i_id_rd;
    logic            i_id_regwrite;
    logic            i_id_memread;
    logic            i_id_branch;
    logic            o_id_stall;
    logic [SELW-1:0] o_ex_fwd_a;
    logic [SELW-1:0] o_ex_fwd_b;
    logic [SELW-1:0] o_id_fwd_a;
    logic [SELW-1:0] o_id_fwd_b;
    logic [15:0]     o_stall_cnt;

    modport master (
        output i_hold, i_flush, i_id_valid, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
               i_id_rd, i_id_regwrite, i_id_memread, i_id_branch,
        input  o_id_stall, o_ex_fwd_a, o_ex_fwd_b, o_id_fwd_a, o_id_fwd_b, o_stall_cnt
    );

    modport slave (
        input  i_hold, i_flush, i_id_valid, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
               i_id_rd, i_id_regwrite, i_id_memread, i_id_branch,
        output o_id_stall, o_ex_fwd_a, o_ex_fwd_b, o_id_fwd_a, o_id_fwd_b, o_stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Scoreboard-based forwarding/hazard unit: destination-tag shift pipeline after ID,
// EX forward selects, load-use stall, stall counter. FWD_BRANCH_EN adds ID branch forwarding.
module fwd_scoreboard #(
    parameter int AW     = 5,
    parameter int DEPTH  = 3,
    parameter int LD_RDY = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fwd_scoreboard_if.slave bus
);
    localparam int SELW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            hit;
        logic            ld;
        logic [SELW-1:0] k;
    } win_t;

    logic [DEPTH:1]  r_valid;
    logic [DEPTH:1]  r_regwr;
    logic [DEPTH:1]  r_memrd;
    logic [AW-1:0]   r_rd [1:DEPTH];
    logic [SELW-1:0] r_ex_fwd_a;
    logic [SELW-1:0] r_ex_fwd_b;
    logic [15:0]     r_stall_cnt;

    logic [DEPTH:1]  w_prod;
    logic [DEPTH:1]  w_match_a;
    logic [DEPTH:1]  w_match_b;
    win_t            w_win_a;
    win_t            w_win_b;
    logic [SELW-1:0] w_ex_sel_a;
    logic [SELW-1:0] w_ex_sel_b;
    logic            w_ex_stall_a;
    logic            w_ex_stall_b;
    logic            w_br_stall;
    logic [SELW-1:0] w_id_fwd_a;
    logic [SELW-1:0] w_id_fwd_b;
    logic            w_stall;
    logic            w_issue;

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_match
            assign w_prod[gi]    = r_valid[gi] && r_regwr[gi] && (r_rd[gi] != '0);
            assign w_match_a[gi] = w_prod[gi] && bus.i_id_use_rs && (r_rd[gi] == bus.i_id_rs);
            assign w_match_b[gi] = w_prod[gi] && bus.i_id_use_rt && (r_rd[gi] == bus.i_id_rt);
        end
    endgenerate

    // Youngest producer (smallest stage index) wins.
    function automatic win_t pick(input logic [DEPTH:1] m, input logic [DEPTH:1] ld);
        win_t w;
        w = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (m[k]) begin
                w.hit = 1'b1;
                w.ld  = ld[k];
                w.k   = SELW'(k);
            end
        end
        return w;
    endfunction

    // The producer sits one stage further along once the consumer reaches EX.
    function automatic logic [SELW:0] ex_select(input win_t w);
        int kk;
        kk = int'(w.k) + 1;
        if (!w.hit || kk > DEPTH)
            return '0;
        else if (w.ld && kk < LD_RDY)
            return {1'b1, {SELW{1'b0}}};
        else
            return {1'b0, SELW'(kk)};
    endfunction

    always_comb begin
        w_win_a = pick(w_match_a, r_memrd);
        w_win_b = pick(w_match_b, r_memrd);
        {w_ex_stall_a, w_ex_sel_a} = ex_select(w_win_a);
        {w_ex_stall_b, w_ex_sel_b} = ex_select(w_win_b);
    end

`ifdef FWD_BRANCH_EN
    logic w_br_stall_a;
    logic w_br_stall_b;

    // Branch compare happens in ID, so no +1 shift; stage 1 is still in EX and not ready.
    always_comb begin
        w_br_stall_a = 1'b0;
        w_br_stall_b = 1'b0;
        w_id_fwd_a   = '0;
        w_id_fwd_b   = '0;
        if (bus.i_id_branch && bus.i_id_valid) begin
            if (w_win_a.hit) begin
                if (int'(w_win_a.k) == 1 || (w_win_a.ld && int'(w_win_a.k) < LD_RDY))
                    w_br_stall_a = 1'b1;
                else
                    w_id_fwd_a = w_win_a.k;
            end
            if (w_win_b.hit) begin
                if (int'(w_win_b.k) == 1 || (w_win_b.ld && int'(w_win_b.k) < LD_RDY))
                    w_br_stall_b = 1'b1;
                else
                    w_id_fwd_b = w_win_b.k;
            end
        end
        w_br_stall = w_br_stall_a || w_br_stall_b;
    end
`else
    logic w_unused_branch;
    assign w_unused_branch = bus.i_id_branch;
    assign w_br_stall      = 1'b0;
    assign w_id_fwd_a      = '0;
    assign w_id_fwd_b      = '0;
`endif

    assign w_stall = bus.i_id_valid && !bus.i_flush && (w_ex_stall_a || w_ex_stall_b || w_br_stall);
    assign w_issue = bus.i_id_valid && !bus.i_flush && !w_stall;

    generate
        for (gi = 2; gi <= DEPTH; gi++) begin : g_shift
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid[gi] <= 1'b0;
                    r_regwr[gi] <= 1'b0;
                    r_memrd[gi] <= 1'b0;
                    r_rd[gi]    <= '0;
                end else if (!bus.i_hold) begin
                    r_valid[gi] <= r_valid[gi-1];
                    r_regwr[gi] <= r_regwr[gi-1];
                    r_memrd[gi] <= r_memrd[gi-1];
                    r_rd[gi]    <= r_rd[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid[1]  <= 1'b0;
            r_regwr[1]  <= 1'b0;
            r_memrd[1]  <= 1'b0;
            r_rd[1]     <= '0;
            r_ex_fwd_a  <= '0;
            r_ex_fwd_b  <= '0;
            r_stall_cnt <= '0;
        end else if (!bus.i_hold) begin
            if (w_issue) begin
                r_valid[1] <= 1'b1;
                r_regwr[1] <= bus.i_id_regwrite;
                r_memrd[1] <= bus.i_id_memread;
                r_rd[1]    <= bus.i_id_rd;
                r_ex_fwd_a <= w_ex_sel_a;
                r_ex_fwd_b <= w_ex_sel_b;
            end else begin
                r_valid[1] <= 1'b0;
                r_regwr[1] <= 1'b0;
                r_memrd[1] <= 1'b0;
                r_rd[1]    <= '0;
                r_ex_fwd_a <= '0;
                r_ex_fwd_b <= '0;
            end
            if (w_stall && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.o_id_stall  = w_stall;
    assign bus.o_ex_fwd_a  = r_ex_fwd_a;
    assign bus.o_ex_fwd_b  = r_ex_fwd_b;
    assign bus.o_id_fwd_a  = w_id_fwd_a;
    assign bus.o_id_fwd_b  = w_id_fwd_b;
    assign bus.o_stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (DEPTH=3, LD_RDY=3); branch cases follow FWD_BRANCH_EN.
module tb_fwd_scoreboard;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_cnt;

    fwd_scoreboard_if #(.AW(5), .DEPTH(3)) bus ();

    fwd_scoreboard #(.AW(5), .DEPTH(3), .LD_RDY(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, expv);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic op(input int rd, input int rs, input int rt, input bit mr, input bit br);
        bus.i_id_valid    = 1'b1;
        bus.i_id_rd       = 5'(rd);
        bus.i_id_rs       = 5'(rs);
        bus.i_id_rt       = 5'(rt);
        bus.i_id_use_rs   = 1'b1;
        bus.i_id_use_rt   = 1'b1;
        bus.i_id_regwrite = !br;
        bus.i_id_memread  = mr;
        bus.i_id_branch   = br;
        #1;
    endtask

    task automatic nop();
        bus.i_id_valid    = 1'b0;
        bus.i_id_rd       = '0;
        bus.i_id_rs       = '0;
        bus.i_id_rt       = '0;
        bus.i_id_use_rs   = 1'b0;
        bus.i_id_use_rt   = 1'b0;
        bus.i_id_regwrite = 1'b0;
        bus.i_id_memread  = 1'b0;
        bus.i_id_branch   = 1'b0;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_cnt = 0;
        rst = 1'b1;
        bus.i_hold = 1'b0;
        bus.i_flush = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_exa", int'(bus.o_ex_fwd_a), 0);
        chk("rst_exb", int'(bus.o_ex_fwd_b), 0);
        chk("rst_cnt", int'(bus.o_stall_cnt), 0);
        chk("rst_stall", int'(bus.o_id_stall), 0);
        chk("rst_idfa", int'(bus.o_id_fwd_a), 0);
        rst = 1'b0;

        // add $8 ; sub $9,$8,$1
        op(8, 1, 2, 0, 0); chk("alu_p_stall", int'(bus.o_id_stall), 0); step();
        op(9, 8, 1, 0, 0); chk("alu_c_stall", int'(bus.o_id_stall), 0); step();
        chk("alu_exa", int'(bus.o_ex_fwd_a), 2);
        chk("alu_exb", int'(bus.o_ex_fwd_b), 0);
        drain();

        // lw $9 ; add $10,$9,$9
        op(9, 1, 0, 1, 0); step();
        op(10, 9, 9, 0, 0); chk("lu_stall", int'(bus.o_id_stall), 1); step(); exp_cnt++;
        chk("lu_cnt", int'(bus.o_stall_cnt), exp_cnt);
        chk("lu_bubble_exa", int'(bus.o_ex_fwd_a), 0);
        chk("lu_stall2", int'(bus.o_id_stall), 0); step();
        chk("lu_exa", int'(bus.o_ex_fwd_a), 3);
        chk("lu_exb", int'(bus.o_ex_fwd_b), 3);
        drain();

        // $0 never forwards
        op(0, 1, 2, 0, 0); step();
        op(3, 0, 0, 0, 0); chk("r0_stall", int'(bus.o_id_stall), 0); step();
        chk("r0_exa", int'(bus.o_ex_fwd_a), 0);
        chk("r0_exb", int'(bus.o_ex_fwd_b), 0);
        drain();

        // producer two back -> stage 3 in EX
        op(8, 1, 2, 0, 0); step(); nop(); step();
        op(4, 8, 0, 0, 0); step();
        chk("two_back_exa", int'(bus.o_ex_fwd_a), 3);
        drain();

        // producer three back -> register file
        op(8, 1, 2, 0, 0); step(); nop(); step(); nop(); step();
        op(4, 8, 0, 0, 0); chk("wf_stall", int'(bus.o_id_stall), 0); step();
        chk("wf_exa", int'(bus.o_ex_fwd_a), 0);
        drain();

        // youngest producer wins
        op(8, 1, 2, 0, 0); step(); op(8, 1, 2, 0, 0); step();
        op(4, 8, 8, 0, 0); step();
        chk("young_exa", int'(bus.o_ex_fwd_a), 2);
        chk("young_exb", int'(bus.o_ex_fwd_b), 2);
        drain();

        // flush kills the consumer, bubble enters stage 1
        op(8, 1, 2, 0, 0); step(); op(8, 1, 2, 0, 0); step();
        op(4, 8, 8, 0, 0); bus.i_flush = 1'b1; #1; step(); bus.i_flush = 1'b0;
        chk("flush_exa", int'(bus.o_ex_fwd_a), 0);
        chk("flush_exb", int'(bus.o_ex_fwd_b), 0);
        op(5, 4, 0, 0, 0); step();
        chk("flush_bubble_exa", int'(bus.o_ex_fwd_a), 0);
        drain();

        // flush beats a load-use stall
        op(9, 1, 0, 1, 0); step();
        op(10, 9, 9, 0, 0); bus.i_flush = 1'b1; #1;
        chk("flush_wins", int'(bus.o_id_stall), 0); step(); bus.i_flush = 1'b0;
        chk("flush_cnt", int'(bus.o_stall_cnt), exp_cnt);
        drain();

        // hold during a load-use stall freezes everything
        op(1, 2, 3, 0, 0); step();
        op(9, 1, 0, 1, 0); step();
        chk("hold_pre_exa", int'(bus.o_ex_fwd_a), 2);
        op(10, 9, 9, 0, 0); bus.i_hold = 1'b1; #1;
        chk("hold_stall", int'(bus.o_id_stall), 1); step();
        chk("hold_exa", int'(bus.o_ex_fwd_a), 2);
        chk("hold_cnt", int'(bus.o_stall_cnt), exp_cnt);
        bus.i_hold = 1'b0; #1;
        chk("hold_rel_stall", int'(bus.o_id_stall), 1); step(); exp_cnt++;
        chk("hold_rel_cnt", int'(bus.o_stall_cnt), exp_cnt);
        chk("hold_rel_exa", int'(bus.o_ex_fwd_a), 0);
        chk("hold_rel_stall2", int'(bus.o_id_stall), 0); step();
        chk("hold_rel_exa2", int'(bus.o_ex_fwd_a), 3);
        drain();

        // asynchronous reset mid-run
        op(8, 1, 2, 0, 0); step();
        op(9, 8, 1, 1, 0); step();
        chk("pre_rst_exa", int'(bus.o_ex_fwd_a), 2);
        op(10, 9, 9, 0, 0); chk("pre_rst_stall", int'(bus.o_id_stall), 1);
        #2; rst = 1'b1; #1;
        exp_cnt = 0;
        chk("arst_exa", int'(bus.o_ex_fwd_a), 0);
        chk("arst_cnt", int'(bus.o_stall_cnt), exp_cnt);
        chk("arst_stall", int'(bus.o_id_stall), 0);
        #1; rst = 1'b0; #1;
        step();
        chk("post_rst_exa", int'(bus.o_ex_fwd_a), 0);
        chk("post_rst_exb", int'(bus.o_ex_fwd_b), 0);
        drain();

`ifdef FWD_BRANCH_EN
        // add $8 ; beq $8,$0
        op(8, 1, 2, 0, 0); step();
        op(0, 8, 0, 0, 1);
        chk("br_alu_stall", int'(bus.o_id_stall), 1);
        chk("br_alu_idfa0", int'(bus.o_id_fwd_a), 0); step(); exp_cnt++;
        chk("br_alu_stall2", int'(bus.o_id_stall), 0);
        chk("br_alu_idfa", int'(bus.o_id_fwd_a), 2);
        chk("br_alu_idfb", int'(bus.o_id_fwd_b), 0);
        chk("br_alu_cnt", int'(bus.o_stall_cnt), exp_cnt);
        drain();

        // lw $8 ; beq $8,$0
        op(8, 1, 0, 1, 0); step();
        op(0, 8, 0, 0, 1);
        chk("br_ld_stall1", int'(bus.o_id_stall), 1); step();
        chk("br_ld_stall2", int'(bus.o_id_stall), 1); step();
        exp_cnt += 2;
        chk("br_ld_stall3", int'(bus.o_id_stall), 0);
        chk("br_ld_idfa", int'(bus.o_id_fwd_a), 3);
        chk("br_ld_cnt", int'(bus.o_stall_cnt), exp_cnt);
        drain();
`else
        // without branch forwarding: no id select, no branch stall
        op(8, 1, 2, 0, 0); step();
        op(0, 8, 0, 0, 1);
        chk("nbr_stall", int'(bus.o_id_stall), 0);
        chk("nbr_idfa", int'(bus.o_id_fwd_a), 0);
        chk("nbr_idfb", int'(bus.o_id_fwd_b), 0); step();
        chk("nbr_exa", int'(bus.o_ex_fwd_a), 2);
        chk("nbr_cnt", int'(bus.o_stall_cnt), exp_cnt);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
